// File: rtl/conv2d_mem_req_mc.sv
// conv2d_mem_req_mc: weight/IFM read and OFM write request generator for a multi-channel strided 2D convolution
module conv2d_mem_req_mc #(
  parameter int WT_DIM = 3,
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int CHW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              wt_reuse_i,
  output logic              idle_o,
  output logic              done_o,
  input  logic [AWIDTH-1:0] fm_width_i,
  input  logic [AWIDTH-1:0] fm_height_i,
  input  logic [CHW-1:0]    num_ch_i,
  input  logic [3:0]        stride_i,
  input  logic [AWIDTH-1:0] wt_offset_i,
  input  logic [AWIDTH-1:0] ifm_offset_i,
  input  logic [AWIDTH-1:0] ofm_offset_i,
  output logic [AWIDTH-1:0] x_o,
  output logic [AWIDTH-1:0] y_o,
  output logic [CHW-1:0]    ch_o,
  output logic              pad_valid_o,
  output logic [AWIDTH-1:0] mem_req_addr_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [DWIDTH-1:0] mem_req_data_o,
  output logic              mem_req_write_o,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              wdata_valid_i
);
  localparam int HALF = WT_DIM >> 1;
  localparam logic [AWIDTH-1:0] KD = AWIDTH'(WT_DIM);
  localparam logic [AWIDTH-1:0] KLAST = AWIDTH'(WT_DIM - 1);
  localparam logic signed [AWIDTH+1:0] HALF_S = (AWIDTH+2)'(HALF);
  typedef enum logic [1:0] {IDLE, READ_WT, READ_IFM, WRITE_OFM} state_t;
  state_t state_q, state_d;
  logic [AWIDTH-1:0] w_q, w_d, h_q, h_d;
  logic [AWIDTH-1:0] wt_off_q, wt_off_d, ifm_off_q, ifm_off_d, ofm_off_q, ofm_off_d;
  logic [CHW-1:0]    nch_q, nch_d, c_q, c_d;
  logic [3:0]        s_q, s_d;
  logic [AWIDTH-1:0] m_q, m_d, n_q, n_d;
  logic [AWIDTH-1:0] xi_q, xi_d, yi_q, yi_d, x_q, x_d, y_q, y_d;
  // Linear output index; equals y*OW + x since outputs are written in raster order.
  logic [AWIDTH-1:0] oidx_q, oidx_d;
  logic signed [AWIDTH+1:0] ix, iy;
  logic halo, fire, last_el, n_wrap, m_wrap, c_wrap, xwrap, ywrap;
  logic [AWIDTH-1:0] n_nx, m_nx, wt_addr, ifm_addr, ofm_addr;
  logic [CHW-1:0] c_nx;
  logic [AWIDTH:0] xi_nx, yi_nx;
  // Window position, halo detection, counter stepping and request outputs.
  always_comb begin
    ix = $signed({2'b0, xi_q}) + $signed({2'b0, n_q}) - HALF_S;
    iy = $signed({2'b0, yi_q}) + $signed({2'b0, m_q}) - HALF_S;
    halo = ix < 0 || iy < 0 || ix >= $signed({2'b0, w_q}) || iy >= $signed({2'b0, h_q});
    n_wrap = n_q == KLAST;
    m_wrap = m_q == KLAST;
    c_wrap = c_q == nch_q - CHW'(1);
    last_el = n_wrap && m_wrap && c_wrap;
    n_nx = n_wrap ? '0 : n_q + 1'b1;
    m_nx = n_wrap ? (m_wrap ? '0 : m_q + 1'b1) : m_q;
    c_nx = (n_wrap && m_wrap) ? (c_wrap ? '0 : c_q + 1'b1) : c_q;
    xi_nx = {1'b0, xi_q} + (AWIDTH+1)'(s_q);
    yi_nx = {1'b0, yi_q} + (AWIDTH+1)'(s_q);
    xwrap = xi_nx >= {1'b0, w_q};
    ywrap = yi_nx >= {1'b0, h_q};
    wt_addr = wt_off_q + (AWIDTH'(c_q) * KD + m_q) * KD + n_q;
    ifm_addr = ifm_off_q + AWIDTH'(c_q) * w_q * h_q + iy[AWIDTH-1:0] * w_q + ix[AWIDTH-1:0];
    ofm_addr = ofm_off_q + oidx_q;
    idle_o = state_q == IDLE;
    pad_valid_o = state_q == READ_IFM && halo;
    mem_req_write_o = state_q == WRITE_OFM && wdata_valid_i;
    mem_req_valid_o = state_q == READ_WT || (state_q == READ_IFM && !halo) || mem_req_write_o;
    mem_req_addr_o = state_q == READ_WT ? wt_addr : state_q == READ_IFM ? ifm_addr : ofm_addr;
    mem_req_data_o = wdata_i;
    fire = mem_req_valid_o && mem_req_ready_i;
    done_o = state_q == WRITE_OFM && fire && xwrap && ywrap;
    x_o = x_q;
    y_o = y_q;
    ch_o = c_q;
  end
  // Next-state logic: config latch on start, element walk in read phases, pixel step on OFM write.
  always_comb begin
    state_d = state_q;
    w_d = w_q;
    h_d = h_q;
    nch_d = nch_q;
    s_d = s_q;
    wt_off_d = wt_off_q;
    ifm_off_d = ifm_off_q;
    ofm_off_d = ofm_off_q;
    c_d = c_q;
    m_d = m_q;
    n_d = n_q;
    xi_d = xi_q;
    yi_d = yi_q;
    x_d = x_q;
    y_d = y_q;
    oidx_d = oidx_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = wt_reuse_i ? READ_IFM : READ_WT;
        w_d = fm_width_i;
        h_d = fm_height_i;
        nch_d = num_ch_i == '0 ? CHW'(1) : num_ch_i;
        s_d = stride_i == '0 ? 4'd1 : stride_i;
        wt_off_d = wt_offset_i;
        ifm_off_d = ifm_offset_i;
        ofm_off_d = ofm_offset_i;
        c_d = '0;
        m_d = '0;
        n_d = '0;
        xi_d = '0;
        yi_d = '0;
        x_d = '0;
        y_d = '0;
        oidx_d = '0;
      end
      READ_WT: if (fire) begin
        c_d = c_nx;
        m_d = m_nx;
        n_d = n_nx;
        state_d = last_el ? READ_IFM : READ_WT;
      end
      READ_IFM: if (halo || fire) begin
        c_d = c_nx;
        m_d = m_nx;
        n_d = n_nx;
        state_d = last_el ? WRITE_OFM : READ_IFM;
      end
      WRITE_OFM: if (fire) begin
        oidx_d = oidx_q + 1'b1;
        xi_d = xwrap ? '0 : xi_nx[AWIDTH-1:0];
        x_d = xwrap ? '0 : x_q + 1'b1;
        yi_d = xwrap ? (ywrap ? '0 : yi_nx[AWIDTH-1:0]) : yi_q;
        y_d = xwrap ? (ywrap ? '0 : y_q + 1'b1) : y_q;
        state_d = (xwrap && ywrap) ? IDLE : READ_IFM;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q <= '0;
      h_q <= '0;
      nch_q <= '0;
      s_q <= '0;
      wt_off_q <= '0;
      ifm_off_q <= '0;
      ofm_off_q <= '0;
      c_q <= '0;
      m_q <= '0;
      n_q <= '0;
      xi_q <= '0;
      yi_q <= '0;
      x_q <= '0;
      y_q <= '0;
      oidx_q <= '0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      h_q <= h_d;
      nch_q <= nch_d;
      s_q <= s_d;
      wt_off_q <= wt_off_d;
      ifm_off_q <= ifm_off_d;
      ofm_off_q <= ofm_off_d;
      c_q <= c_d;
      m_q <= m_d;
      n_q <= n_d;
      xi_q <= xi_d;
      yi_q <= yi_d;
      x_q <= x_d;
      y_q <= y_d;
      oidx_q <= oidx_d;
    end
  end
endmodule

// File: tb/tb_conv2d_mem_req_mc.sv
// tb_conv2d_mem_req_mc: table-driven and randomized check of the conv2d request generator against a loop-nest model
module tb_conv2d_mem_req_mc;
  logic clk, rst, start, wt_reuse, idle, done, pad_valid;
  logic mem_req_valid, mem_req_ready, mem_req_write, wdata_valid;
  logic [31:0] fm_width, fm_height, wt_offset, ifm_offset, ofm_offset, x, y, mem_req_addr, mem_req_data, wdata;
  logic [7:0] num_ch, ch;
  logic [3:0] stride;
  int n_chk = 0, n_fail = 0;

  typedef struct {int kind; logic [31:0] addr; int ch; int x; int y;} ev_t;
  typedef struct {int w, h, c, s; bit reuse; logic [31:0] wo, io, oo; int stall; bit wr_rand; int n_rd, n_pad, n_wr;} vec_t;
  ev_t exp_q[$];

  conv2d_mem_req_mc dut (
    .clk(clk), .rst(rst), .start_i(start), .wt_reuse_i(wt_reuse), .idle_o(idle), .done_o(done),
    .fm_width_i(fm_width), .fm_height_i(fm_height), .num_ch_i(num_ch), .stride_i(stride),
    .wt_offset_i(wt_offset), .ifm_offset_i(ifm_offset), .ofm_offset_i(ofm_offset),
    .x_o(x), .y_o(y), .ch_o(ch), .pad_valid_o(pad_valid), .mem_req_addr_o(mem_req_addr),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_req_data_o(mem_req_data),
    .mem_req_write_o(mem_req_write), .wdata_i(wdata), .wdata_valid_i(wdata_valid)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected event stream: loop nest straight from the job definition (0 read, 1 write, 2 pad).
  task automatic build_model(vec_t v);
    int cc, ss, idx, oy, ox, ix, iy;
    cc = v.c == 0 ? 1 : v.c;
    ss = v.s == 0 ? 1 : v.s;
    exp_q.delete();
    if (!v.reuse)
      for (int c = 0; c < cc; c++)
        for (int m = 0; m < 3; m++)
          for (int n = 0; n < 3; n++)
            exp_q.push_back('{0, v.wo + 32'((c * 3 + m) * 3 + n), c, 0, 0});
    idx = 0;
    oy = 0;
    for (int yi = 0; yi < v.h; yi += ss) begin
      ox = 0;
      for (int xi = 0; xi < v.w; xi += ss) begin
        for (int c = 0; c < cc; c++)
          for (int m = 0; m < 3; m++)
            for (int n = 0; n < 3; n++) begin
              ix = xi - 1 + n;
              iy = yi - 1 + m;
              if (ix < 0 || iy < 0 || ix >= v.w || iy >= v.h) exp_q.push_back('{2, 32'd0, c, 0, 0});
              else exp_q.push_back('{0, v.io + 32'(c * v.w * v.h + iy * v.w + ix), c, 0, 0});
            end
        exp_q.push_back('{1, v.oo + 32'(idx), 0, ox, oy});
        idx++;
        ox++;
      end
      oy++;
    end
  endtask

  task automatic take(int k);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("extra_event", 64'(k), 64'hFFFF);
      return;
    end
    e = exp_q.pop_front();
    chk("kind", 64'(k), 64'(e.kind));
    if (k == e.kind) begin
      if (k != 2) chk("addr", mem_req_addr, e.addr);
      if (k == 1) begin
        chk("x", x, 32'(e.x));
        chk("y", y, 32'(e.y));
        chk("wdata", mem_req_data, wdata);
      end else chk("ch", ch, 8'(e.ch));
    end
  endtask

  task automatic run_job(vec_t v);
    int cyc, nrd, nwr, npad;
    bit fin, ph, fw;
    logic [31:0] paddr;
    build_model(v);
    @(posedge clk); #1;
    chk("idle_before_start", idle, 1);
    fm_width = v.w; fm_height = v.h; num_ch = 8'(v.c); stride = 4'(v.s); wt_reuse = v.reuse;
    wt_offset = v.wo; ifm_offset = v.io; ofm_offset = v.oo; start = 1;
    @(posedge clk); #1;
    start = 0;
    fm_width = $urandom; fm_height = $urandom; num_ch = 8'($urandom); stride = 4'($urandom);
    wt_reuse = 1'($urandom); wt_offset = $urandom; ifm_offset = $urandom; ofm_offset = $urandom;
    cyc = 0; nrd = 0; nwr = 0; npad = 0; fin = 0; ph = 0; paddr = 0;
    while (!fin && cyc < 20000) begin
      mem_req_ready = $urandom_range(99) >= v.stall;
      wdata_valid = v.wr_rand ? 1'($urandom) : 1'b1;
      wdata = $urandom;
      start = 1'($urandom);
      @(negedge clk);
      if (ph) begin
        chk("hold_valid", mem_req_valid, 1);
        chk("hold_addr", mem_req_addr, paddr);
        chk("hold_write", mem_req_write, 0);
      end
      fw = mem_req_valid && mem_req_ready && mem_req_write;
      if (mem_req_valid && mem_req_ready) begin
        if (mem_req_write) nwr++; else nrd++;
        take(mem_req_write ? 1 : 0);
      end
      if (pad_valid) begin
        npad++;
        take(2);
      end
      chk("done", done, fw && exp_q.size() == 0);
      fin = done || (fw && exp_q.size() == 0);
      ph = mem_req_valid && !mem_req_ready && !mem_req_write;
      paddr = mem_req_addr;
      cyc++;
      @(posedge clk); #1;
    end
    start = 0;
    if (!fin) chk("job_timeout", 0, 1);
    chk("events_left", 64'(exp_q.size()), 0);
    if (v.n_wr >= 0) begin
      chk("n_reads", 64'(nrd), 64'(v.n_rd));
      chk("n_pads", 64'(npad), 64'(v.n_pad));
      chk("n_writes", 64'(nwr), 64'(v.n_wr));
    end
    @(negedge clk);
    chk("idle_after_done", idle, 1);
    chk("valid_after_done", mem_req_valid, 0);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    tbl[0] = '{3, 3, 1, 1, 0, 32'd0, 32'd100, 32'd200, 0, 0, 58, 32, 9};
    tbl[1] = '{4, 2, 2, 2, 0, 32'd1000, 32'd5000, 32'd9000, 0, 0, 38, 16, 2};
    tbl[2] = '{1, 1, 1, 1, 0, 32'd7, 32'd70, 32'd700, 30, 0, 10, 8, 1};
    tbl[3] = '{3, 5, 1, 3, 0, 32'd10, 32'd20, 32'd30, 30, 0, 19, 8, 2};
    tbl[4] = '{2, 1, 0, 0, 1, 32'd500, 32'd600, 32'd800, 0, 0, 4, 14, 2};
    tbl[5] = '{3, 3, 1, 1, 0, 32'd0, 32'd100, 32'd200, 30, 1, 58, 32, 9};
    rst = 1; start = 0; wt_reuse = 0; fm_width = 0; fm_height = 0; num_ch = 0; stride = 0;
    wt_offset = 0; ifm_offset = 0; ofm_offset = 0; mem_req_ready = 0; wdata = 0; wdata_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_idle", idle, 1);
    chk("rst_done", done, 0);
    chk("rst_valid", mem_req_valid, 0);
    chk("rst_write", mem_req_write, 0);
    chk("rst_pad", pad_valid, 0);
    chk("rst_xy", {x, y}, 0);
    chk("rst_ch", ch, 0);
    for (int i = 0; i < 6; i++) run_job(tbl[i]);
    // Abort in the middle of the IFM phase.
    @(posedge clk); #1;
    fm_width = 4; fm_height = 4; num_ch = 1; stride = 1; wt_reuse = 1;
    wt_offset = 0; ifm_offset = 32'h100; ofm_offset = 32'h200; start = 1; mem_req_ready = 1; wdata_valid = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("busy_before_rst", idle, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("abort_idle", idle, 1);
    chk("abort_valid", mem_req_valid, 0);
    chk("abort_pad", pad_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_quiet", {idle, mem_req_valid, pad_valid}, 3'b100);
    end
    run_job(tbl[1]);
    for (int i = 0; i < 10; i++) begin
      v.w = $urandom_range(1, 6); v.h = $urandom_range(1, 5); v.c = $urandom_range(0, 3); v.s = $urandom_range(0, 4);
      v.reuse = 1'($urandom); v.wo = $urandom; v.io = $urandom; v.oo = $urandom;
      v.stall = 30; v.wr_rand = 1'($urandom); v.n_rd = -1; v.n_pad = -1; v.n_wr = -1;
      run_job(v);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
